// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
package lsu_pkg;
    localparam int OFF_W = 2;
    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, ILLEGAL = 2'b11} mem_size_e;
    typedef enum logic [1:0] {IDLE = 2'b00, BUS = 2'b01, RESP = 2'b10} lsu_state_e;
    typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_MISALIGN = 2'b01, ERR_ILLEGAL = 2'b10, ERR_TIMEOUT = 2'b11} err_code_e;
endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: byte-lane steering for stores and lane extraction/extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [OFF_W-1:0] st_off,
    input  mem_size_e        st_size,
    input  logic [31:0]      st_wdata,
    output logic [3:0]       st_be,
    output logic [31:0]      st_lanes,
    output logic             st_misaligned,
    input  logic [OFF_W-1:0] ld_off,
    input  mem_size_e        ld_size,
    input  logic             ld_unsigned,
    input  logic [31:0]      ld_word,
    output logic [31:0]      ld_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    always_comb begin
        st_be         = st_size == BYTE ? 4'b0001 << st_off :
                        st_size == HALF ? 4'b0011 << st_off :
                        st_size == WORD ? 4'b1111 : 4'b0000;
        st_lanes      = st_size == BYTE ? {4{st_wdata[7:0]}} :
                        st_size == HALF ? {2{st_wdata[15:0]}} : st_wdata;
        st_misaligned = (st_size == HALF && st_off[0]) || (st_size == WORD && st_off != 2'b00);
        ld_byte       = ld_word[{ld_off, 3'b000} +: 8];
        ld_half       = ld_word[{ld_off[1], 4'b0000} +: 16];
        ld_data       = ld_size == BYTE ? {{24{~ld_unsigned & ld_byte[7]}}, ld_byte} :
                        ld_size == HALF ? {{16{~ld_unsigned & ld_half[15]}}, ld_half} : ld_word;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time data-memory access stage with req/ack bus and timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        resp_err_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    lsu_state_e        state, state_n;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-3:0] waddr_q;
    logic [OFF_W-1:0]  off_q;
    mem_size_e         size_q;
    logic              uns_q, we_q;
    logic [3:0]        be_q, st_be;
    logic [31:0]       wdata_q, rdata_q, st_lanes, ld_data;
    err_code_e         err_q, err_in;
    logic              st_mis, illegal, direct, accept, expire;

    lsu_align u_align (
        .st_off       (addr[1:0]),
        .st_size      (mem_size_e'(mem_size)),
        .st_wdata     (wdata),
        .st_be        (st_be),
        .st_lanes     (st_lanes),
        .st_misaligned(st_mis),
        .ld_off       (off_q),
        .ld_size      (size_q),
        .ld_unsigned  (uns_q),
        .ld_word      (bus_rdata),
        .ld_data      (ld_data)
    );

    // Illegal takes priority over misaligned; no-ops also skip the bus.
    always_comb begin
        illegal = mem_size == ILLEGAL || (mem_read && mem_write);
        err_in  = illegal ? ERR_ILLEGAL : st_mis ? ERR_MISALIGN : ERR_NONE;
        direct  = err_in != ERR_NONE || (!mem_read && !mem_write);
        accept  = req_valid && state == IDLE;
        expire  = state == BUS && !bus_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
        state_n = state == IDLE ? (req_valid ? (direct ? RESP : BUS) : IDLE) :
                  state == BUS  ? ((bus_ack || expire) ? RESP : BUS) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            waddr_q <= '0;
            off_q   <= '0;
            size_q  <= BYTE;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_NONE;
        end else if (accept) begin
            cnt     <= '0;
            waddr_q <= addr[ADDR_W-1:2];
            off_q   <= addr[1:0];
            size_q  <= mem_size_e'(mem_size);
            uns_q   <= mem_unsigned;
            we_q    <= mem_write;
            be_q    <= st_be;
            wdata_q <= st_lanes;
            rdata_q <= '0;
            err_q   <= err_in;
        end else if (state == BUS) begin
            if (bus_ack)     rdata_q <= we_q ? '0 : ld_data;
            else if (expire) err_q   <= ERR_TIMEOUT;
            else             cnt     <= cnt + 1'b1;
        end
    end

    always_comb begin
        req_ready     = state == IDLE;
        resp_valid    = state == RESP;
        resp_rdata    = resp_valid ? rdata_q : '0;
        resp_err_code = resp_valid ? err_q : ERR_NONE;
        resp_err      = resp_valid && err_q != ERR_NONE;
        bus_req       = state == BUS;
        bus_we        = bus_req && we_q;
        bus_addr      = bus_req ? {waddr_q, 2'b00} : '0;
        bus_be        = bus_req ? be_q : '0;
        bus_wdata     = bus_req ? wdata_q : '0;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of instruction decode. It consumes the decoded memory controls: mem_read, mem_write, mem_size, mem_unsigned, plus the ALU-computed address and the rs2 store data. It runs one transaction at a time on a word-wide data-memory bus with a req/ack handshake. It returns load data that has been lane-aligned and sign- or zero-extended, or an error for misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, bus cycles waited for bus_ack before aborting; must be >= 1.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  pipeline presents a memory op.
req_ready  out  1  unit can accept; high only in IDLE.
mem_read  in  1  load request.
mem_write  in  1  store request.
mem_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
mem_unsigned  in  1  1=zero-extend load, 0=sign-extend.
addr  in  ADDR_W  byte address.
wdata  in  32  store data from rs2, LSB-justified.
resp_valid  out  1  one-cycle pulse: op complete.
resp_rdata  out  32  extended load data; 0 for stores, no-ops and errors.
resp_err  out  1  qualifies resp_valid; op failed.
resp_err_code  out  2  00=none, 01=misaligned, 10=illegal (size 11 or read&write), 11=bus timeout.
bus_req  out  1  bus transaction request.
bus_we  out  1  1=write.
bus_addr  out  ADDR_W  word-aligned address, with addr[1:0] forced to 0.
bus_be  out  4  byte enables.
bus_wdata  out  32  lane-replicated store data.
bus_ack  in  1  bus completes the transaction this cycle.
bus_rdata  in  32  read word, valid with bus_ack.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - All outputs are 0 except req_ready=1.
  - Timeout counter is 0.
  - bus_req drops immediately, even mid-transaction. The aborted op gets no response.
- FSM states are IDLE, BUS and RESP.
- IDLE:
  - Accept on req_valid && req_ready at edge T. Register addr, size, unsigned, we, and the byte-enables and data from lane steering.
  - Illegal or misaligned op: go to RESP, with resp_valid at T+1 and the error code set.
    - Illegal means mem_size=11 or mem_read&&mem_write. Illegal is checked before misaligned.
    - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - No-op (neither read nor write): go to RESP, with resp_valid at T+1, err=0 and rdata=0.
  - Otherwise go to BUS.
- BUS:
  - bus_req=1 from T+1. bus_we, bus_addr, bus_be and bus_wdata are held stable until ack.
  - On bus_ack: latch the extended read data and go to RESP. bus_req falls the next cycle.
  - Minimum latency is accept at T, ack at T+1, resp_valid at T+2.
  - The counter increments on each BUS cycle without ack. When counter == TIMEOUT_CYCLES-1 and there is still no ack, go to RESP with err code 11 and drop bus_req.
  - An ack in that same final cycle wins over the timeout.
  - The counter clears on entry to BUS.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE with req_ready=1.
  - There is no response backpressure.
  - Back-to-back ops: the next accept is possible in the cycle after resp_valid.
- Store lane steering (off = addr[1:0]):
  - Byte: be = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - Half: be = 4'b0011<<off, wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111, wdata unchanged.
- Load extraction:
  - Byte lane is bus_rdata[8*off +: 8]. Half lane is bus_rdata[16*off[1] +: 16].
  - Extend by mem_unsigned. Word passes through.
  - Loads drive be for the accessed lanes, exactly as stores do.
- resp_rdata holds its value only while resp_valid=1 and is 0 otherwise.

Decomposition:
- Package lsu_pkg:
  - mem_size_e (BYTE, HALF, WORD, ILLEGAL).
  - lsu_state_e (IDLE, BUS, RESP).
  - err_code_e (ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT).
  - Width constant for the 2-bit lane offset.
- One combinational sub-module, lsu_align:
  - Store side: off/size/wdata -> be/bus_wdata, plus the misaligned flag.
  - Load side: off/size/unsigned/bus_rdata -> extended data.
  - It is instantiated once. The FSM, timeout counter and registers live in load_store_unit.

Test Plan:
1. Word load, addr=0x1000, bus_ack on first BUS cycle with bus_rdata=0xDEADBEEF -> bus_addr=0x1000, be=1111, resp_valid at T+2, rdata=0xDEADBEEF, err=0.
2. Signed byte load, addr=0x1003, rdata=0x80112233 -> be=1000, resp_rdata=0xFFFFFF80. Same with unsigned -> 0x00000080. Unsigned half at 0x1002 -> 0x00008011.
3. Byte store, addr=0x2001, wdata=0x000000A5 -> bus_we=1, bus_addr=0x2000, be=0010, bus_wdata=0xA5A5A5A5, rdata=0. Half store at 0x2002, wdata=0x1234 -> be=1100, bus_wdata=0x12341234.
4. Errors, all with no bus_req and resp_valid at T+1:
   - Word load addr=0x1002 -> code 01.
   - mem_size=11 -> code 10.
   - read&write both set -> code 10.
5. No bus_ack ever, TIMEOUT_CYCLES=4 -> bus_req high for exactly 4 cycles, then resp_err=1, code 11, and req_ready returns. Ack arriving in the 4th cycle -> normal response.
6. Assert rst_n=0 while in BUS with bus_req=1 -> bus_req=0 immediately, no resp_valid, req_ready=1. Two back-to-back word stores -> second accepted the cycle after the first resp_valid.
